// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Brief    : Shared line geometry, fill state encoding and line-base helper.
// Revision : 1.0
// ============================================================================
package cache_pkg;

    localparam int LINE_BITS      = 512;
    localparam int WORD_BITS      = 32;
    localparam int ADDR_BITS      = 32;
    localparam int WORDS_PER_LINE = 16;
    localparam int OFFSET_BITS    = 6;
    localparam int BEAT_BITS      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } fill_state_t;

    function automatic logic [ADDR_BITS-1:0] line_base(input logic [ADDR_BITS-1:0] addr);
        line_base = {addr[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fill_beat_ctr.sv
`default_nettype none
// ============================================================================
// Module   : fill_beat_ctr
// Brief    : Modulo-16 beat counter with loadable start and last-beat flag.
// Revision : 1.0
// ============================================================================
module fill_beat_ctr
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [BEAT_BITS-1:0] start,
    input  logic                 advance,
    output logic [BEAT_BITS-1:0] beat,
    output logic                 last
);

    logic [BEAT_BITS-1:0] r_beat;
    logic [BEAT_BITS-1:0] r_start;
    logic [BEAT_BITS-1:0] w_beat_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_beat  <= '0;
            r_start <= '0;
        end else if (load) begin
            r_beat  <= start;
            r_start <= start;
        end else if (advance) begin
            r_beat  <= w_beat_next;
        end
    end

    // The burst ends when wrapping would bring us back to where it began.
    assign w_beat_next = r_beat + {{(BEAT_BITS-1){1'b0}}, 1'b1};
    assign beat        = r_beat;
    assign last        = (w_beat_next == r_start);

endmodule
`default_nettype wire

// File: rtl/line_fill_unit.sv
`default_nettype none
// ============================================================================
// Module   : line_fill_unit
// Brief    : Cache miss handler: optional dirty write-back, then 16-beat refill.
//            CRITICAL_WORD_FIRST_EN starts the refill at the missing word.
// Revision : 1.0
// ============================================================================
module line_fill_unit
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic                 req_wb,
    input  logic [ADDR_BITS-1:0] wb_addr,
    input  logic [LINE_BITS-1:0] wb_data,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WORD_BITS-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [WORD_BITS-1:0] mem_rdata,
    output logic [LINE_BITS-1:0] fill_data,
    output logic                 fill_valid,
    output logic                 busy
);

    fill_state_t          r_state;
    fill_state_t          w_state_next;
    logic [ADDR_BITS-1:0] r_req_base;
    logic [ADDR_BITS-1:0] r_wb_base;
    logic [LINE_BITS-1:0] r_wb_data;
    logic [LINE_BITS-1:0] r_fill_data;

    logic                 w_accept;
    logic                 w_ctr_load;
    logic [BEAT_BITS-1:0] w_ctr_start;
    logic                 w_ctr_adv;
    logic [BEAT_BITS-1:0] w_beat;
    logic                 w_last;
    logic [ADDR_BITS-1:0] w_beat_off;
    logic [BEAT_BITS-1:0] w_rd_start_in;
    logic [BEAT_BITS-1:0] w_rd_start;

`ifdef CRITICAL_WORD_FIRST_EN
    logic [BEAT_BITS-1:0] r_rd_start;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_start <= '0;
        end else if (w_accept) begin
            r_rd_start <= req_addr[OFFSET_BITS-1:2];
        end
    end

    assign w_rd_start_in = req_addr[OFFSET_BITS-1:2];
    assign w_rd_start    = r_rd_start;
`else
    assign w_rd_start_in = '0;
    assign w_rd_start    = '0;
`endif

    assign w_accept = req_valid && (r_state == IDLE);

    fill_beat_ctr u_beat_ctr (
        .clk     (clk),
        .rst     (rst),
        .load    (w_ctr_load),
        .start   (w_ctr_start),
        .advance (w_ctr_adv),
        .beat    (w_beat),
        .last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_req_base  <= '0;
            r_wb_base   <= '0;
            r_wb_data   <= '0;
            r_fill_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_req_base <= line_base(req_addr);
                r_wb_base  <= line_base(wb_addr);
                r_wb_data  <= wb_data;
            end
            if ((r_state == RD) && mem_ack) begin
                r_fill_data[{w_beat, 5'd0} +: WORD_BITS] <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ctr_load   = 1'b0;
        w_ctr_start  = '0;
        w_ctr_adv    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_ctr_load = 1'b1;
                    if (req_wb) begin
                        w_state_next = WB;
                    end else begin
                        w_state_next = RD;
                        w_ctr_start  = w_rd_start_in;
                    end
                end
            end
            WB: begin
                if (mem_ack) begin
                    if (w_last) begin
                        w_state_next = RD;
                        w_ctr_load   = 1'b1;
                        w_ctr_start  = w_rd_start;
                    end else begin
                        w_ctr_adv = 1'b1;
                    end
                end
            end
            RD: begin
                if (mem_ack) begin
                    w_ctr_adv = 1'b1;
                    if (w_last) begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_beat_off = {{(ADDR_BITS-BEAT_BITS-2){1'b0}}, w_beat, 2'b00};

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (r_state == WB) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_wb_base + w_beat_off;
            mem_wdata = r_wb_data[{w_beat, 5'd0} +: WORD_BITS];
        end else if (r_state == RD) begin
            mem_req  = 1'b1;
            mem_addr = r_req_base + w_beat_off;
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign fill_valid = (r_state == DONE);
    assign fill_data  = r_fill_data;

endmodule
`default_nettype wire

// File: tb/tb_line_fill_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_fill_unit
// Brief    : Directed/randomized self-checking bench for line_fill_unit.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_line_fill_unit;
    import cache_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic [ADDR_BITS-1:0] req_addr = '0;
    logic                 req_wb = 1'b0;
    logic [ADDR_BITS-1:0] wb_addr = '0;
    logic [LINE_BITS-1:0] wb_data = '0;
    logic                 mem_req;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [WORD_BITS-1:0] mem_wdata;
    logic                 mem_ack = 1'b0;
    logic [WORD_BITS-1:0] mem_rdata = '0;
    logic [LINE_BITS-1:0] fill_data;
    logic                 fill_valid;
    logic                 busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [LINE_BITS-1:0] exp_fill = '0;

    line_fill_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wb     (req_wb),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .fill_data  (fill_data),
        .fill_valid (fill_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [LINE_BITS-1:0] obs,
                       input logic [LINE_BITS-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [LINE_BITS-1:0] rand_line();
        logic [LINE_BITS-1:0] l;
        for (int k = 0; k < WORDS_PER_LINE; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    // Runs one miss from accept to the DONE cycle; called and returns at a negedge.
    task automatic do_miss(input logic [31:0] raddr, input bit wb, input logic [31:0] waddr,
                           input logic [LINE_BITS-1:0] wdata, input int waits,
                           input bit hold_valid, input bit fixed_rdata);
        logic [31:0]          rbase, wbase, exp_addr;
        logic [31:0]          rd [16];
        logic [LINE_BITS-1:0] line;
        int                   start, nbeats, idx;
        bit                   is_wr;
        rbase = {raddr[31:6], 6'b0};
        wbase = {waddr[31:6], 6'b0};
`ifdef CRITICAL_WORD_FIRST_EN
        start = int'(raddr[5:2]);
`else
        start = 0;
`endif
        for (int k = 0; k < 16; k++) rd[k] = fixed_rdata ? 32'hA000_0000 + k : $urandom;
        chk("ready_idle", req_ready, 1);
        chk("no_fill_idle", fill_valid, 0);
        req_valid = 1'b1; req_addr = raddr; req_wb = wb; wb_addr = waddr; wb_data = wdata;
        mem_ack = 1'b0;
        step();
        if (!hold_valid) begin
            req_valid = 1'b0; req_addr = $urandom; wb_addr = $urandom;
            req_wb = 1'($urandom); wb_data = rand_line();
        end
        line   = exp_fill;
        nbeats = wb ? 32 : 16;
        for (int b = 0; b < nbeats; b++) begin
            is_wr    = wb && (b < 16);
            idx      = is_wr ? b : (start + b - (wb ? 16 : 0)) % 16;
            exp_addr = (is_wr ? wbase : rbase) + 32'(4 * idx);
            for (int w = 0; w <= waits; w++) begin
                chk("mem_req", mem_req, 1);
                chk("mem_we", mem_we, is_wr);
                chk("mem_addr", mem_addr, exp_addr);
                chk("busy", busy, 1);
                chk("fill_valid_low", fill_valid, 0);
                if (is_wr) begin
                    chk("mem_wdata", mem_wdata, wdata[32*idx +: 32]);
                    chk("fill_hold", fill_data, exp_fill);
                end
                mem_ack   = (w == waits);
                mem_rdata = (!is_wr && w == waits) ? rd[idx] : $urandom;
                step();
            end
            if (!is_wr) line[32*idx +: 32] = rd[idx];
        end
        mem_ack = 1'b0;
        chk("fill_valid", fill_valid, 1);
        chk("fill_data", fill_data, line);
        chk("done_mem_req", mem_req, 0);
        chk("done_ready", req_ready, 0);
        exp_fill = line;
        step();
    endtask

    initial begin
        logic [LINE_BITS-1:0] seq_line;
        logic [31:0]          ra, wa;
        logic [LINE_BITS-1:0] wd;
        bit                   dirty;

        // Reset state
        rst = 1'b0;
        repeat (3) step();
        chk("rst_ready", req_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_fill_data", fill_data, 0);
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        step();

        // Clean miss, known read data
        do_miss(32'h0000_1040, 1'b0, 32'h0, '0, 0, 1'b0, 1'b1);

        // Dirty miss, victim word k = k
        for (int k = 0; k < 16; k++) seq_line[32*k +: 32] = 32'(k);
        do_miss($urandom, 1'b1, 32'h0000_2000, seq_line, 0, 1'b0, 1'b0);

        // Three wait states on every beat
        do_miss($urandom, 1'b0, $urandom, rand_line(), 3, 1'b0, 1'b0);

        // Reset in the middle of a write-back
        chk("ready_pre_rst", req_ready, 1);
        req_valid = 1'b1; req_wb = 1'b1; req_addr = 32'h0000_3000;
        wb_addr = 32'h0000_4000; wb_data = rand_line();
        step();
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        repeat (5) step();
        chk("rst_beat5_addr", mem_addr, 32'h0000_4014);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("abort_mem_req", mem_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_fill_valid", fill_valid, 0);
        chk("abort_mem_addr", mem_addr, 0);
        exp_fill = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_ack_ignored_req", mem_req, 0);
            chk("idle_ack_ignored_fv", fill_valid, 0);
            chk("idle_ack_ignored_busy", busy, 0);
        end
        mem_ack = 1'b0;
        do_miss($urandom, 1'b1, $urandom, rand_line(), 0, 1'b0, 1'b0);

        // req_valid held high across a miss: re-accept right after DONE
        ra = $urandom; wa = $urandom; wd = rand_line(); dirty = 1'($urandom);
        do_miss(ra, dirty, wa, wd, 0, 1'b1, 1'b0);
        do_miss(ra, dirty, wa, wd, 0, 1'b0, 1'b0);

        // Critical-word address, then randomized misses
        do_miss(32'h0000_1074, 1'b0, $urandom, rand_line(), 1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            do_miss($urandom, 1'($urandom), $urandom, rand_line(),
                    int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

        chk("end_ready", req_ready, 1);
        chk("end_fill_valid", fill_valid, 0);
        chk("end_fill_hold", fill_data, exp_fill);
        step();
        chk("end_fill_hold2", fill_data, exp_fill);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
